// File: rtl/ultrasonic_pkg.sv
// Shared types and defaults for the ultrasonic rangefinder scheduler.
package ultrasonic_pkg;

    // Scheduler sequence: one channel at a time, always ending in a guard interval.
    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitEcho,
        StMeasure,
        StGuard
    } state_e;

    // Defaults sized for a 50 MHz system clock.
    localparam int unsigned DEF_N_CH           = 4;
    localparam int unsigned DEF_TRIG_CYCLES    = 500;      // 10 us trigger pulse
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1900000;  // 38 ms echo window
    localparam int unsigned DEF_GUARD_CYCLES   = 3000000;  // 60 ms inter-ping gap
    localparam int unsigned DEF_CNT_W          = 22;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for asynchronous echo pins plus rise/fall edge detection.
// Edges are taken between the synchronized level and its one-cycle-delayed copy,
// so both edges see the same latency and a measured width matches the raw width.
module echo_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    // Synchronizer chain and edge-history register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin measurement scheduler for N ultrasonic rangefinders.
// Each selected channel goes through trigger, echo wait, width measurement and a
// guard interval; only one channel is ever active so sensors cannot crosstalk.
module ultrasonic_scheduler
    import ultrasonic_pkg::*;
#(
    parameter int unsigned N_CH           = DEF_N_CH,
    parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned GUARD_CYCLES   = DEF_GUARD_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [N_CH-1:0]             ch_mask,
    input  logic [N_CH-1:0]             echo,
    output logic [N_CH-1:0]             trig,
    output logic                        busy,
    output logic                        dist_valid,
    output logic [ch_idx_w(N_CH)-1:0]   dist_ch,
    output logic [CNT_W-1:0]            dist_data,
    output logic                        dist_timeout
);

    localparam int unsigned CH_W = ch_idx_w(N_CH);
    // One spare bit so sel + offset never overflows before the wrap subtraction.
    localparam int unsigned CW1  = CH_W + 1;

    localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [N_CH-1:0]  TRIG_ONE   = {{(N_CH-1){1'b0}}, 1'b1};

    state_e            state_q;
    logic [CH_W-1:0]   sel_q;     // channel in service, or last serviced while idle
    logic [CNT_W-1:0]  cnt_q;     // trigger length, timeout or guard count by state
    logic [CNT_W-1:0]  width_q;

    logic [N_CH-1:0]   echo_level;
    logic [N_CH-1:0]   echo_rise;
    logic [N_CH-1:0]   echo_fall;

    logic              sel_level;
    logic              sel_rise;
    logic              sel_fall;
    logic              tout_hit;
    logic [CNT_W-1:0]  width_inc;
    logic [CNT_W-1:0]  cnt_inc;

    logic [CH_W-1:0]   next_ch;
    logic              ch_found;
    logic [CW1-1:0]    cand;

    echo_sync #(
        .WIDTH (N_CH)
    ) u_echo_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (echo),
        .level    (echo_level),
        .rise     (echo_rise),
        .fall     (echo_fall)
    );

    // Only the channel in service is observed.
    assign sel_level = echo_level[sel_q];
    assign sel_rise  = echo_rise[sel_q];
    assign sel_fall  = echo_fall[sel_q];

    // Timeout fires on the cycle the count reaches TIMEOUT_CYCLES.
    assign tout_hit  = (cnt_q >= TOUT_LAST);
    assign cnt_inc   = cnt_q + 1'b1;
    assign width_inc = (width_q == '1) ? width_q : width_q + 1'b1;

    // Next enabled channel strictly after the last serviced one, wrapping to 0.
    always_comb begin
        next_ch  = sel_q;
        ch_found = 1'b0;
        cand     = '0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            cand = {1'b0, sel_q} + CW1'(i);
            if (cand >= CW1'(N_CH)) begin
                cand = cand - CW1'(N_CH);
            end
            if (!ch_found && ch_mask[cand[CH_W-1:0]]) begin
                ch_found = 1'b1;
                next_ch  = cand[CH_W-1:0];
            end
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            sel_q        <= CH_W'(N_CH - 1);
            cnt_q        <= '0;
            width_q      <= '0;
            trig         <= '0;
            busy         <= 1'b0;
            dist_valid   <= 1'b0;
            dist_ch      <= '0;
            dist_data    <= '0;
            dist_timeout <= 1'b0;
        end else begin
            dist_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enable && ch_found) begin
                        sel_q   <= next_ch;
                        trig    <= TRIG_ONE << next_ch;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StTrig;
                    end
                end

                StTrig: begin
                    if (cnt_q == TRIG_LAST) begin
                        trig    <= '0;
                        cnt_q   <= '0;
                        state_q <= StWaitEcho;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end

                StWaitEcho: begin
                    if (tout_hit) begin
                        dist_valid   <= 1'b1;
                        dist_ch      <= sel_q;
                        dist_data    <= '1;
                        dist_timeout <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= StGuard;
                    end else begin
                        cnt_q <= cnt_inc;
                        // A level already high on entry never produces a rise here.
                        if (sel_rise) begin
                            width_q <= '0;
                            state_q <= StMeasure;
                        end
                    end
                end

                StMeasure: begin
                    if (tout_hit) begin
                        dist_valid   <= 1'b1;
                        dist_ch      <= sel_q;
                        dist_data    <= '1;
                        dist_timeout <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= StGuard;
                    end else if (sel_fall) begin
                        // The rise-detect cycle was high but not counted; add it here.
                        dist_valid   <= 1'b1;
                        dist_ch      <= sel_q;
                        dist_data    <= width_inc;
                        dist_timeout <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= StGuard;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (sel_level) begin
                            width_q <= width_inc;
                        end
                    end
                end

                StGuard: begin
                    if (cnt_q == GUARD_LAST) begin
                        cnt_q   <= '0;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end

                default: begin
                    trig    <= '0;
                    busy    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler with hand-computed expectations.
module tb_ultrasonic_scheduler;

    localparam int unsigned N_CH           = 4;
    localparam int unsigned TRIG_CYCLES    = 10;
    localparam int unsigned TIMEOUT_CYCLES = 200;
    localparam int unsigned GUARD_CYCLES   = 50;
    localparam int unsigned CNT_W          = 22;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic [N_CH-1:0]  ch_mask;
    logic [N_CH-1:0]  echo;
    logic [N_CH-1:0]  trig;
    logic             busy;
    logic             dist_valid;
    logic [1:0]       dist_ch;
    logic [CNT_W-1:0] dist_data;
    logic             dist_timeout;

    int errors     = 0;
    int checks     = 0;
    int cyc        = 0;
    int trig_rises = 0;
    int overlaps   = 0;
    logic [N_CH-1:0] trig_prev = '0;

    ultrasonic_scheduler #(
        .N_CH           (N_CH),
        .TRIG_CYCLES    (TRIG_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .GUARD_CYCLES   (GUARD_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .ch_mask      (ch_mask),
        .echo         (echo),
        .trig         (trig),
        .busy         (busy),
        .dist_valid   (dist_valid),
        .dist_ch      (dist_ch),
        .dist_data    (dist_data),
        .dist_timeout (dist_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Trigger activity monitor: rising-edge count and one-hot violations.
    always @(negedge clk) begin
        if (trig != '0 && trig_prev == '0) trig_rises <= trig_rises + 1;
        if (!$onehot0(trig)) overlaps <= overlaps + 1;
        trig_prev <= trig;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Each wait returns the number of negedges until the condition was seen.
    task automatic wait_trig(input int limit, output int n, output logic ok);
        n = 0;
        ok = 1'b0;
        while (n < limit && !ok) begin
            @(negedge clk);
            n++;
            if (trig != '0) ok = 1'b1;
        end
    endtask

    task automatic wait_trig_low(input int limit, output int n, output logic ok);
        n = 0;
        ok = 1'b0;
        while (n < limit && !ok) begin
            @(negedge clk);
            n++;
            if (trig == '0) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(input int limit, output int n, output logic ok);
        n = 0;
        ok = 1'b0;
        while (n < limit && !ok) begin
            @(negedge clk);
            n++;
            if (dist_valid) ok = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        logic ok;
        int rises;
        int t_res;
        int t_prev;
        int rr_ch [4];
        logic [N_CH-1:0] exp_trig;
        int c;

        rr_ch   = '{0, 1, 3, 0};
        t_prev  = 0;
        reset_n = 1'b0;
        enable  = 1'b0;
        ch_mask = '0;
        echo    = '0;

        // Reset values
        step(3);
        check("rst_trig", trig, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", dist_valid, 0);
        check("rst_ch", dist_ch, 0);
        check("rst_data", dist_data, 0);
        check("rst_tout", dist_timeout, 0);
        reset_n = 1'b1;
        step(3);
        check("idle_busy", busy, 0);
        check("idle_trig", trig, 0);

        // Basic measurement on channel 0, echo 37 cycles
        ch_mask = 4'b0001;
        enable  = 1'b1;
        wait_trig(10, n, ok);
        check("b_trig_seen", ok, 1);
        check("b_trig_lat", n, 1);
        check("b_trig_val", trig, 4'b0001);
        check("b_busy", busy, 1);
        wait_trig_low(50, n, ok);
        check("b_trig_fall_seen", ok, 1);
        check("b_trig_len", n, TRIG_CYCLES);
        step(3);
        echo[0] = 1'b1;
        step(37);
        echo[0] = 1'b0;
        wait_valid(20, n, ok);
        check("b_valid_seen", ok, 1);
        check("b_valid_lat", n, 3);
        check("b_ch", dist_ch, 0);
        check("b_data", dist_data, 37);
        check("b_tout", dist_timeout, 0);
        ch_mask = 4'b0010;
        step(1);
        check("b_valid_pulse", dist_valid, 0);
        check("b_data_hold", dist_data, 37);

        // Timeout on channel 1 (one cycle already spent after the result)
        wait_trig(100, n, ok);
        check("c_trig_seen", ok, 1);
        check("c_guard_gap", n, GUARD_CYCLES);
        check("c_trig_val", trig, 4'b0010);
        wait_valid(400, n, ok);
        check("c_valid_seen", ok, 1);
        check("c_valid_lat", n, TRIG_CYCLES + TIMEOUT_CYCLES);
        check("c_ch", dist_ch, 1);
        check("c_data", dist_data, 32'h3FFFFF);
        check("c_tout", dist_timeout, 1);

        // Stuck-high echo on channel 0: high through trigger, then falls and pulses 12
        ch_mask = 4'b0001;
        echo[0] = 1'b1;
        wait_trig(100, n, ok);
        check("d_trig_seen", ok, 1);
        check("d_guard_gap", n, GUARD_CYCLES + 1);
        check("d_trig_val", trig, 4'b0001);
        wait_trig_low(50, n, ok);
        check("d_trig_fall_seen", ok, 1);
        step(5);
        echo[0] = 1'b0;
        step(4);
        echo[0] = 1'b1;
        step(12);
        echo[0] = 1'b0;
        wait_valid(30, n, ok);
        check("d_valid_seen", ok, 1);
        check("d_valid_lat", n, 3);
        check("d_ch", dist_ch, 0);
        check("d_data", dist_data, 12);
        check("d_tout", dist_timeout, 0);

        // Enable dropped mid-measurement
        wait_trig(100, n, ok);
        check("e_trig_seen", ok, 1);
        check("e_guard_gap", n, GUARD_CYCLES + 1);
        wait_trig_low(50, n, ok);
        check("e_trig_fall_seen", ok, 1);
        step(2);
        echo[0] = 1'b1;
        step(10);
        enable = 1'b0;
        step(20);
        echo[0] = 1'b0;
        wait_valid(30, n, ok);
        check("e_valid_seen", ok, 1);
        check("e_data", dist_data, 30);
        check("e_busy_guard", busy, 1);
        rises = trig_rises;
        step(GUARD_CYCLES);
        check("e_busy_idle", busy, 0);
        step(100);
        check("e_no_trig", trig_rises, rises);
        check("e_trig_zero", trig, 0);

        // Async reset during trigger
        ch_mask = 4'b1011;
        enable  = 1'b1;
        wait_trig(10, n, ok);
        check("f_trig_seen", ok, 1);
        check("f_trig_val", trig, 4'b0010);
        step(3);
        #2 reset_n = 1'b0;
        #1;
        check("f_rst_trig", trig, 0);
        check("f_rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_trig(10, n, ok);
        check("f_post_seen", ok, 1);
        check("f_post_lat", n, 1);
        check("f_post_ch0", trig, 4'b0001);

        // Round-robin with channel 2 masked off; echo width 5+ch
        for (int k = 0; k < 4; k++) begin
            c = rr_ch[k];
            exp_trig = '0;
            exp_trig[c] = 1'b1;
            if (k > 0) begin
                wait_trig(150, n, ok);
                check("g_trig_seen", ok, 1);
            end
            check("g_trig_order", trig, exp_trig);
            wait_trig_low(50, n, ok);
            check("g_trig_fall_seen", ok, 1);
            step(2);
            echo[c] = 1'b1;
            step(5 + c);
            echo[c] = 1'b0;
            wait_valid(30, n, ok);
            check("g_valid_seen", ok, 1);
            check("g_ch", dist_ch, c);
            check("g_data", dist_data, 5 + c);
            check("g_tout", dist_timeout, 0);
            t_res = cyc;
            if (k > 0) check("g_gap", (t_res - t_prev) >= 50, 1);
            t_prev = t_res;
        end

        check("no_trig_overlap", overlaps, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ultrasonic_scheduler.md
# ultrasonic_scheduler

Round-robin measurement scheduler that shares the sensor time slot among N ultrasonic rangefinders. It sequences one sensor at a time through trigger, echo wait, pulse-width measurement and an inter-ping guard interval, so no two sensors ever ping concurrently and crosstalk is avoided. Each completed measurement is published as a single-cycle result strobe carrying the channel index and the echo width in clock cycles. It sits between the raw sensor pins and the distance-conversion/display logic.

## Interface
- N_CH, 4: number of sensor channels (2..16)
- TRIG_CYCLES, 500: trigger pulse width in clk cycles (10 µs at 50 MHz)
- TIMEOUT_CYCLES, 1900000: max cycles from trigger end to echo fall (38 ms)
- GUARD_CYCLES, 3000000: idle cycles after each measurement before the next trigger (60 ms)
- CNT_W, 22: counter/result width; must hold max(TIMEOUT_CYCLES, GUARD_CYCLES)
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  run scheduling when high
- ch_mask  input  N_CH  channel enable mask; bit i set = channel i is scheduled
- echo  input  N_CH  raw echo pins, asynchronous
- trig  output  N_CH  trigger pins, one-hot or zero
- busy  output  1  high in any state other than IDLE
- dist_valid  output  1  one-cycle result strobe
- dist_ch  output  clog2(N_CH)  channel of the current result
- dist_data  output  CNT_W  echo width in cycles; all-ones on timeout
- dist_timeout  output  1  qualifies dist_valid: measurement timed out

## Operation
- States: IDLE, TRIG, WAIT_ECHO, MEASURE, GUARD.
- IDLE: if enable and ch_mask≠0, select the next set mask bit strictly after the last serviced channel, wrapping from N_CH-1 to 0. Go to TRIG. After reset, the last-serviced channel is N_CH-1, so channel 0 is tried first.
- TRIG: drive trig[sel] high for exactly TRIG_CYCLES cycles, then go to WAIT_ECHO. The timeout counter clears on entry to WAIT_ECHO.
- WAIT_ECHO: wait for a 0→1 edge on the synchronized echo[sel]. An echo already high on entry is ignored until it falls and rises again. On the edge, go to MEASURE with the width counter cleared.
- MEASURE: the width counter increments every cycle the synchronized echo is high. On the 1→0 edge, publish width and go to GUARD.
- Timeout: the timeout counter runs through WAIT_ECHO and MEASURE. On reaching TIMEOUT_CYCLES, publish dist_timeout=1 with dist_data all-ones and go to GUARD.
- GUARD: wait GUARD_CYCLES cycles, then go to IDLE. The guard always completes.
- enable low mid-sequence: the current channel finishes, including its guard, then the block stays in IDLE.
- ch_mask change: sampled only in IDLE. A channel removed mid-measurement still completes.
- Only echo[sel] is observed; other echo lines are ignored.
- Width counter saturates at all-ones and never wraps. Timeout has priority if it coincides with the falling edge.

## Timing
- Reset values: trig=0, busy=0, dist_valid=0, dist_ch=0, dist_data=0, dist_timeout=0, state=IDLE.
- echo passes a 2-FF synchronizer. The reported width equals the raw high-time in whole cycles because the synchronizer delay cancels.
- All outputs are registered. dist_valid rises one cycle after the synchronized falling edge is detected, or one cycle after the timeout count is reached.
- dist_ch, dist_data and dist_timeout hold their values until the next dist_valid.
- IDLE→TRIG takes 1 cycle; trig rises the cycle after leaving IDLE.
- reset_n low at any time clears state immediately and forces trig=0 asynchronously.

## Structure
- Package ultrasonic_pkg holds:
  - the state enum
  - default cycle constants for 50 MHz
  - a clog2-based channel-index width function
- Sub-module echo_sync: 2-FF synchronizer plus rise/fall edge detector, instantiated once per channel with width N_CH.
- The round-robin next-channel finder stays inline as combinational logic.

## Test plan
All scenarios use N_CH=4, TRIG_CYCLES=10, TIMEOUT_CYCLES=200, GUARD_CYCLES=50.
- Basic measurement: ch_mask=4'b0001, echo[0] high for 37 cycles → trig[0] high 10 cycles; dist_valid with dist_ch=0, dist_data=37, dist_timeout=0.
- Round-robin with skip: ch_mask=4'b1011, each echo of width 5+i → triggers in order 0,1,3,0, no channel 2; no two trig bits high together; ≥50 cycles between results.
- Timeout: no echo on ch1 → dist_valid 210 cycles after trig rise, dist_timeout=1, dist_data all-ones; next trigger only after guard.
- Stuck-high echo: echo[0] high before trigger, then falls, rises and lasts 12 cycles → dist_data=12.
- Enable drop mid-MEASURE → result still delivered, guard completes, then busy=0 with no further trig.
- Async reset asserted during TRIG → trig=0 immediately; after release, the first trigger goes to channel 0.
